// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, replays on cache miss or stall, flushes on redirect; optional FETCH_PERF_EN counters.
// Latency: hit result reaches IF/ID two cycles after its address; miss adds 2 bubbles, redirect refills in 2.
// Backpressure: ifid_stall holds IF/ID and re-presents the pending address until released.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] inst_addr,
  input  logic [31:0] cache_inst,
  input  logic        cache_hit,
  input  logic        ifid_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc,
  output logic        ifid_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_miss_count,
  output logic [31:0] perf_stall_count,
  output logic [31:0] perf_fetch_count
`endif
);

  typedef enum logic {
    RUN     = 1'b0,
    DISCARD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] ifid_inst_d, ifid_pc_d;
  logic        ifid_valid_d;
  logic        consume;

  assign inst_addr = pc_q;
  assign consume   = (state_q == RUN) & cache_hit & ~ifid_stall & ~redirect_valid;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= DISCARD;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      ifid_inst  <= NOP_INST;
      ifid_pc    <= 32'h0;
      ifid_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      ifid_inst  <= ifid_inst_d;
      ifid_pc    <= ifid_pc_d;
      ifid_valid <= ifid_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    ifid_inst_d  = ifid_inst;
    ifid_pc_d    = ifid_pc;
    ifid_valid_d = ifid_valid;
    if (redirect_valid) begin
      // Redirect beats stall and miss: the whole pipe front is squashed.
      pc_d         = redirect_pc & ~32'd3;
      state_d      = DISCARD;
      ifid_valid_d = 1'b0;
    end else if (state_q == DISCARD) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
      state_d  = RUN;
      if (!ifid_stall) ifid_valid_d = 1'b0;
    end else if (consume) begin
      ifid_inst_d  = cache_inst;
      ifid_pc_d    = req_pc_q;
      ifid_valid_d = 1'b1;
      req_pc_d     = pc_q;
      pc_d         = pc_q + 32'd4;
    end else begin
      // The address in flight behind req_pc_q is dropped and refetched later.
      pc_d    = req_pc_q;
      state_d = DISCARD;
      if (!ifid_stall) ifid_valid_d = 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_miss_count  <= 32'h0;
      perf_stall_count <= 32'h0;
      perf_fetch_count <= 32'h0;
    end else begin
      if ((state_q == RUN) && !cache_hit && !redirect_valid)
        perf_miss_count <= perf_miss_count + 32'd1;
      if (ifid_stall) perf_stall_count <= perf_stall_count + 32'd1;
      if (consume) perf_fetch_count <= perf_fetch_count + 32'd1;
    end
  end
`endif

endmodule
